// File: rtl/alu_seq_datapath.sv
// Multi-cycle ALU datapath: buffered operands, start/opcode command, single IDLE/EXEC/DONE FSM.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for opcode 111.
module alu_seq_datapath #(
  parameter int ALU_SIZE   = 8,
  parameter int MUL_CYCLES = ALU_SIZE
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ALU_SIZE-1:0] alu_data_a,
  input  logic [ALU_SIZE-1:0] alu_data_b,
  input  logic                store_a,
  input  logic                store_b,
  input  logic [2:0]          opcode_value,
  input  logic                start,
  output logic                busy,
  output logic                alu_done,
  output logic [ALU_SIZE-1:0] result,
  output logic                overflow,
  output logic                op_error
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_PAR = 3'b010, OP_CMP = 3'b011,
    OP_AND = 3'b100, OP_OR  = 3'b101, OP_XOR = 3'b110, OP_MUL = 3'b111
  } op_e;

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [ALU_SIZE-1:0] buf_a_q, buf_a_d, buf_b_q, buf_b_d;
  logic [ALU_SIZE-1:0] a_q, a_d, b_q, b_d;
  logic [ALU_SIZE-1:0] result_q, result_d;
  logic                overflow_q, overflow_d;
  logic                op_error_q, op_error_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_mul;

  logic [ALU_SIZE-1:0] alu_res;
  logic                alu_ovf;
  logic                alu_err;

`ifdef ALU_MUL_EN
  // Accumulator: upper half gathers partial sums, lower half holds the unconsumed multiplier bits.
  logic [2*ALU_SIZE-1:0] prod_q, prod_d, mul_next;
  logic [ALU_SIZE:0]     mul_sum;

  always_comb begin
    mul_sum  = {1'b0, prod_q[2*ALU_SIZE-1:ALU_SIZE]} + (prod_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, prod_q[ALU_SIZE-1:1]};
  end

  assign is_mul = (op_q == OP_MUL);
`else
  assign is_mul = 1'b0;
`endif

  // Single-cycle operations; opcode 111 lands in default and flags op_error when no multiplier exists.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (op_q)
      OP_ADD:  {alu_ovf, alu_res} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  {alu_ovf, alu_res} = {1'b0, a_q} - {1'b0, b_q};
      OP_PAR:  alu_res = ALU_SIZE'(^{a_q, b_q});
      OP_CMP:  alu_res = ALU_SIZE'({a_q < b_q, a_q == b_q, a_q > b_q});
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    buf_a_d    = buf_a_q;
    buf_b_d    = buf_b_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    op_error_d = op_error_q;
    cnt_d      = cnt_q;
`ifdef ALU_MUL_EN
    prod_d     = prod_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (store_a) buf_a_d = alu_data_a;
        if (store_b) buf_b_d = alu_data_b;
        if (start && !store_a && !store_b) begin
          a_d     = buf_a_q;
          b_d     = buf_b_q;
          op_d    = op_e'(opcode_value);
          cnt_d   = '0;
`ifdef ALU_MUL_EN
          prod_d  = {{ALU_SIZE{1'b0}}, buf_b_q};
`endif
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
`ifdef ALU_MUL_EN
        prod_d = mul_next;
`endif
        if (is_mul && (cnt_q != CNT_LAST)) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = S_DONE;
`ifdef ALU_MUL_EN
          if (is_mul) begin
            result_d   = mul_next[ALU_SIZE-1:0];
            overflow_d = |mul_next[2*ALU_SIZE-1:ALU_SIZE];
            op_error_d = 1'b0;
          end else
`endif
          begin
            result_d   = alu_res;
            overflow_d = alu_ovf;
            op_error_d = alu_err;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_ADD;
      buf_a_q    <= '0;
      buf_b_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      op_error_q <= 1'b0;
      cnt_q      <= '0;
`ifdef ALU_MUL_EN
      prod_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every flop captures values from before this edge.
      state_q    <= state_d;
      op_q       <= op_d;
      buf_a_q    <= buf_a_d;
      buf_b_q    <= buf_b_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      op_error_q <= op_error_d;
      cnt_q      <= cnt_d;
`ifdef ALU_MUL_EN
      prod_q     <= prod_d;
`endif
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign alu_done = (state_q == S_DONE);
  assign result   = result_q;
  assign overflow = overflow_q;
  assign op_error = op_error_q;

endmodule

// File: tb/tb_alu_seq_datapath.sv
// Scoreboard bench for alu_seq_datapath (ALU_SIZE=8); expectations follow ALU_MUL_EN when defined.
module tb_alu_seq_datapath;

  logic       clk;
  logic       reset_n;
  logic [7:0] alu_data_a, alu_data_b;
  logic       store_a, store_b;
  logic [2:0] opcode_value;
  logic       start;
  logic       busy, alu_done, overflow, op_error;
  logic [7:0] result;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    logic       err;
    int         lat;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  alu_seq_datapath #(.ALU_SIZE(8), .MUL_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_data_a(alu_data_a), .alu_data_b(alu_data_b),
    .store_a(store_a), .store_b(store_b),
    .opcode_value(opcode_value), .start(start),
    .busy(busy), .alu_done(alu_done), .result(result),
    .overflow(overflow), .op_error(op_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input string name, input logic [7:0] r, input logic o,
                          input logic e, input int lat);
    exp_t x;
    x.res = r; x.ovf = o; x.err = e; x.lat = lat; x.name = name;
    sb.push_back(x);
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    alu_data_a = a; alu_data_b = b; store_a = 1'b1; store_b = 1'b1;
    @(negedge clk);
    store_a = 1'b0; store_b = 1'b0;
  endtask

  // Issues one command, waits (bounded) for alu_done, then checks scoreboard entry, latency and busy.
  task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] r,
                        input logic o, input logic e, input int lat);
    exp_t x;
    int   n, busy_n;
    bit   seen;
    push_exp(name, r, o, e, lat);
    @(negedge clk);
    opcode_value = op; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    busy_n = busy ? 1 : 0;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (busy) busy_n++;
      if (alu_done) seen = 1;
    end
    x = sb.pop_front();
    n_assert++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: alu_done not seen within %0d cycles", x.name, n);
    end else begin
      n_assert++;
      if (result !== x.res) begin
        n_fail++; $display("FAIL %s_result: got %h expected %h", x.name, result, x.res);
      end
      n_assert++;
      if (overflow !== x.ovf) begin
        n_fail++; $display("FAIL %s_overflow: got %b expected %b", x.name, overflow, x.ovf);
      end
      n_assert++;
      if (op_error !== x.err) begin
        n_fail++; $display("FAIL %s_op_error: got %b expected %b", x.name, op_error, x.err);
      end
      n_assert++;
      if (n !== x.lat) begin
        n_fail++; $display("FAIL %s_latency: got %0d expected %0d", x.name, n, x.lat);
      end
      n_assert++;
      if (busy_n !== x.lat + 1) begin
        n_fail++; $display("FAIL %s_busy_cycles: got %0d expected %0d", x.name, busy_n, x.lat + 1);
      end
      @(posedge clk); #1;
      n_assert++;
      if (alu_done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_done_pulse: done=%b busy=%b expected 0 0", x.name, alu_done, busy);
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    alu_data_a = '0; alu_data_b = '0; store_a = 0; store_b = 0;
    opcode_value = '0; start = 0;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({busy, alu_done, result, overflow, op_error} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b result=%h ovf=%b err=%b expected all 0",
               busy, alu_done, result, overflow, op_error);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add;
    load(8'hF0, 8'h20);
    run_op("add", 3'b000, 8'h10, 1'b1, 1'b0, 1);
  endtask

  task automatic test_sub_comp;
    load(8'h05, 8'h07);
    run_op("sub", 3'b001, 8'hFE, 1'b1, 1'b0, 1);
    load(8'h33, 8'h33);
    run_op("comp_eq", 3'b011, 8'h02, 1'b0, 1'b0, 1);
    load(8'h40, 8'h10);
    run_op("comp_gt", 3'b011, 8'h01, 1'b0, 1'b0, 1);
    run_op("add_nocarry", 3'b000, 8'h50, 1'b0, 1'b0, 1);
  endtask

  task automatic test_mul;
    load(8'h12, 8'h0F);
`ifdef ALU_MUL_EN
    run_op("mul", 3'b111, 8'h0E, 1'b1, 1'b0, 8);
    load(8'h0B, 8'h0D);
    run_op("mul_small", 3'b111, 8'h8F, 1'b0, 1'b0, 8);
`else
    run_op("mul_off", 3'b111, 8'h00, 1'b0, 1'b1, 1);
`endif
  endtask

  task automatic test_logic;
    load(8'h81, 8'h01);
    run_op("par", 3'b010, 8'h01, 1'b0, 1'b0, 1);
    run_op("xor", 3'b110, 8'h80, 1'b0, 1'b0, 1);
    run_op("and", 3'b100, 8'h01, 1'b0, 1'b0, 1);
    run_op("or",  3'b101, 8'h81, 1'b0, 1'b0, 1);
    run_op("comp_lt_swap", 3'b011, 8'h01, 1'b0, 1'b0, 1);
  endtask

  task automatic test_ignore;
    exp_t x;
    int   pulses;
    // start with store_a in the same cycle: store happens, start does not.
    @(negedge clk);
    alu_data_a = 8'h55; store_a = 1'b1; opcode_value = 3'b000; start = 1'b1;
    @(posedge clk); #1;
    store_a = 1'b0; start = 1'b0;
    pulses = 0;
    repeat (3) begin
      n_assert++;
      if (busy !== 1'b0) begin
        n_fail++; $display("FAIL start_with_store_busy: got %b expected 0", busy);
      end
      if (alu_done) pulses++;
      @(posedge clk); #1;
    end
    n_assert++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL start_with_store_done: got %0d pulses expected 0", pulses);
    end
    @(negedge clk);
    alu_data_b = 8'h22; store_b = 1'b1;
    @(negedge clk);
    store_b = 1'b0;
    // Store and start held through EXEC and DONE must have no effect.
    push_exp("exec_ignore", 8'h77, 1'b0, 1'b0, 1);
    @(negedge clk);
    opcode_value = 3'b000; start = 1'b1;
    @(posedge clk); #1;
    alu_data_a = 8'hAA; store_a = 1'b1; opcode_value = 3'b001;
    pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin
        store_a = 1'b0; start = 1'b0;
        n_assert++;
        if (busy !== 1'b0) begin
          n_fail++; $display("FAIL done_cycle_start_busy: got %b expected 0", busy);
        end
      end
      if (alu_done) begin
        pulses++;
        x = sb.pop_front();
        n_assert++;
        if (result !== x.res) begin
          n_fail++; $display("FAIL %s_result: got %h expected %h", x.name, result, x.res);
        end
      end
    end
    n_assert++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL exec_ignore_pulses: got %0d expected 1", pulses);
    end
    run_op("buf_a_kept", 3'b000, 8'h77, 1'b0, 1'b0, 1);
  endtask

  task automatic test_back_to_back;
    exp_t x;
    bit   done_at[8];
    push_exp("b2b_first", 8'h77, 1'b0, 1'b0, 1);
    push_exp("b2b_second", 8'h77, 1'b0, 1'b0, 1);
    @(negedge clk);
    opcode_value = 3'b000; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      done_at[i] = alu_done;
      if (i == 2) begin
        n_assert++;
        if (busy !== 1'b0) begin
          n_fail++; $display("FAIL b2b_done_cycle_start: busy=%b expected 0", busy);
        end
      end
      if (i == 3) start = 1'b0;
      if (alu_done && sb.size() > 0) begin
        x = sb.pop_front();
        n_assert++;
        if (result !== x.res || overflow !== x.ovf) begin
          n_fail++;
          $display("FAIL %s_result: got %h/%b expected %h/%b", x.name, result, overflow, x.res, x.ovf);
        end
      end
    end
    n_assert++;
    if (!(done_at[1] && done_at[4]) || done_at[2] || done_at[3] || done_at[5] || done_at[6]) begin
      n_fail++;
      $display("FAIL b2b_done_timing: pattern %b%b%b%b%b%b expected 100100",
               done_at[1], done_at[2], done_at[3], done_at[4], done_at[5], done_at[6]);
    end
    n_assert++;
    if (sb.size() !== 0) begin
      n_fail++; $display("FAIL b2b_scoreboard: %0d entries left expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_mid;
    load(8'h12, 8'h0F);
    @(negedge clk);
    opcode_value = 3'b111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_assert++;
    if ({busy, alu_done, result, overflow, op_error} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: busy=%b done=%b result=%h ovf=%b err=%b expected all 0",
               busy, alu_done, result, overflow, op_error);
    end
    @(negedge clk);
    reset_n = 1'b1;
    load(8'h01, 8'h01);
    run_op("after_reset_add", 3'b000, 8'h02, 1'b0, 1'b0, 1);
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub_comp;
    test_mul;
    test_logic;
    test_ignore;
    test_back_to_back;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
